// File: rtl/audio_stream_ctrl.sv
// UART-to-DAC stream sequencer: frame assembly, sample-rate read strobe, playback FSM, host flow control.
// Optional event counters are built only when AUDIO_STREAM_CTRL_STATS_EN is defined.
module audio_stream_ctrl #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int SAMPLE_FREQ  = 44_100,
  parameter int FILL_BITS    = 12,
  parameter int START_LEVEL  = 2048,
  parameter int LOW_LEVEL    = 1228,
  parameter int HIGH_LEVEL   = 2867,
  parameter int BYTE_TIMEOUT = 1200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx_received,
  input  logic [7:0]           rx_data,
  input  logic [FILL_BITS-1:0] fifo_fill,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [31:0]          fifo_wr_data,
  output logic                 fifo_rd_en,
  output logic                 dac_mute,
  output logic                 host_go,
  output logic [1:0]           state,
  output logic [7:0]           underrun_count,
  output logic [7:0]           overflow_count,
  output logic [7:0]           resync_count
);

  localparam int ACC_W  = $clog2(CLK_FREQ + SAMPLE_FREQ + 1);
  localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);

  localparam logic [ACC_W-1:0]     CLK_INC    = ACC_W'(CLK_FREQ);
  localparam logic [ACC_W-1:0]     SAMPLE_INC = ACC_W'(SAMPLE_FREQ);
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT = IDLE_W'(BYTE_TIMEOUT);
  localparam logic [FILL_BITS-1:0] START_L    = FILL_BITS'(START_LEVEL);
  localparam logic [FILL_BITS-1:0] LOW_L      = FILL_BITS'(LOW_LEVEL);
  localparam logic [FILL_BITS-1:0] HIGH_L     = FILL_BITS'(HIGH_LEVEL);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREBUF = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  logic [1:0]        byte_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [ACC_W-1:0]  phase_acc;
  logic [ACC_W-1:0]  phase_sum;
  logic              tick;
  logic              timeout;
  logic              frame_done;
  logic              underrun;

  assign phase_sum  = phase_acc + SAMPLE_INC;
  assign tick       = (phase_sum >= CLK_INC);
  assign timeout    = !rx_received && (byte_idx != 2'd0) && (idle_cnt == IDLE_LIMIT);
  assign frame_done = rx_received && (byte_idx == 2'd3);
  assign underrun   = (state == ST_PLAY) && enable && tick && fifo_empty;
  assign dac_mute   = (state != ST_PLAY);

  // The assembly register doubles as the write data, so it stays stable until the next byte lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      idle_cnt     <= '0;
      fifo_wr_data <= 32'd0;
      fifo_wr_en   <= 1'b0;
    end else begin
      fifo_wr_en <= frame_done && !fifo_full;
      if (rx_received) begin
        idle_cnt <= '0;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    fifo_wr_data[23:16] <= rx_data;
          2'd1:    fifo_wr_data[31:24] <= rx_data;
          2'd2:    fifo_wr_data[7:0]   <= rx_data;
          default: fifo_wr_data[15:8]  <= rx_data;
        endcase
      end else begin
        if (idle_cnt != IDLE_LIMIT)
          idle_cnt <= idle_cnt + 1'b1;
        if (timeout)
          byte_idx <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_acc  <= '0;
      fifo_rd_en <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      phase_acc  <= tick ? (phase_sum - CLK_INC) : phase_sum;
      fifo_rd_en <= (state == ST_PLAY) && enable && tick && !fifo_empty;
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:   state <= ST_PREBUF;
          ST_PREBUF: if (fifo_fill >= START_L) state <= ST_PLAY;
          ST_PLAY:   if (underrun) state <= ST_PREBUF;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  // Hysteresis keeps the host line from chattering around a single threshold.
  always_ff @(posedge clk) begin
    if (reset)
      host_go <= 1'b1;
    else if (fifo_fill <= LOW_L)
      host_go <= 1'b1;
    else if (fifo_fill >= HIGH_L)
      host_go <= 1'b0;
  end

`ifdef AUDIO_STREAM_CTRL_STATS_EN
  logic overflow;
  assign overflow = frame_done && fifo_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= 8'd0;
      overflow_count <= 8'd0;
      resync_count   <= 8'd0;
    end else begin
      if (underrun && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 8'd1;
      if (overflow && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 8'd1;
      if (timeout && resync_count != 8'hFF)
        resync_count <= resync_count + 8'd1;
    end
  end
`else
  assign underrun_count = 8'd0;
  assign overflow_count = 8'd0;
  assign resync_count   = 8'd0;
`endif

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl; scaled clock/sample rates keep the tick-count window short.
// Expected counter values follow AUDIO_STREAM_CTRL_STATS_EN.
module tb_audio_stream_ctrl;

  localparam int CLK_FREQ     = 1200;
  localparam int SAMPLE_FREQ  = 441;
  localparam int FILL_BITS    = 12;
  localparam int BYTE_TIMEOUT = 40;

`ifdef AUDIO_STREAM_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 rx_received;
  logic [7:0]           rx_data;
  logic [FILL_BITS-1:0] fifo_fill;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [31:0]          fifo_wr_data;
  logic                 fifo_rd_en;
  logic                 dac_mute;
  logic                 host_go;
  logic [1:0]           state;
  logic [7:0]           underrun_count;
  logic [7:0]           overflow_count;
  logic [7:0]           resync_count;

  int assertCount = 0;
  int failCount   = 0;

  audio_stream_ctrl #(
    .CLK_FREQ(CLK_FREQ), .SAMPLE_FREQ(SAMPLE_FREQ), .FILL_BITS(FILL_BITS),
    .START_LEVEL(2048), .LOW_LEVEL(1228), .HIGH_LEVEL(2867), .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_received(rx_received), .rx_data(rx_data),
    .fifo_fill(fifo_fill), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .dac_mute(dac_mute), .host_go(host_go), .state(state),
    .underrun_count(underrun_count), .overflow_count(overflow_count),
    .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    rx_data     = data;
    rx_received = 1'b1;
    stepCycle();
    rx_received = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  int rdSeen;
  int fillTab [7] = '{2866, 2867, 3000, 2000, 1229, 1228, 2000};
  int goTab   [7] = '{1, 0, 0, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; enable = 1'b0; rx_received = 1'b0; rx_data = 8'd0;
    fifo_fill = '0; fifo_empty = 1'b0; fifo_full = 1'b0;
    idleCycles(2);
    reset = 1'b0;

    checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_wr_data", fifo_wr_data, 32'd0);
    checkOutput("rst_mute", 32'(dac_mute), 32'd1);
    checkOutput("rst_host_go", 32'(host_go), 32'd1);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_count), 32'd0);
    checkOutput("rst_resync", 32'(resync_count), 32'd0);

    // Basic frame: left then right, each little-endian.
    applyStimulus(8'h34); applyStimulus(8'h12); applyStimulus(8'h78);
    checkOutput("frame1_no_early_wr", 32'(fifo_wr_en), 32'd0);
    applyStimulus(8'h56);
    checkOutput("frame1_wr_en", 32'(fifo_wr_en), 32'd1);
    checkOutput("frame1_data", fifo_wr_data, 32'h1234_5678);
    stepCycle();
    checkOutput("frame1_wr_single", 32'(fifo_wr_en), 32'd0);

    // Gap shorter than the timeout keeps the partial frame.
    applyStimulus(8'hAA); applyStimulus(8'hBB);
    idleCycles(20);
    applyStimulus(8'hCC); applyStimulus(8'hDD);
    checkOutput("gap_wr_en", 32'(fifo_wr_en), 32'd1);
    checkOutput("gap_data", fifo_wr_data, 32'hBBAA_DDCC);
    checkOutput("gap_resync", 32'(resync_count), 32'd0);

    // Long gap discards the partial frame.
    applyStimulus(8'h55); applyStimulus(8'h66);
    idleCycles(BYTE_TIMEOUT + 5);
    checkOutput("timeout_resync", 32'(resync_count), 32'(STATS));
    applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h02);
    checkOutput("timeout_no_early_wr", 32'(fifo_wr_en), 32'd0);
    applyStimulus(8'h00);
    checkOutput("timeout_wr_en", 32'(fifo_wr_en), 32'd1);
    checkOutput("timeout_data", fifo_wr_data, 32'h0001_0002);

    // Reset mid-frame restarts assembly and clears counters.
    applyStimulus(8'h11); applyStimulus(8'h22);
    reset = 1'b1; stepCycle(); reset = 1'b0;
    checkOutput("midrst_data", fifo_wr_data, 32'd0);
    checkOutput("midrst_resync", 32'(resync_count), 32'd0);
    applyStimulus(8'h34); applyStimulus(8'h12); applyStimulus(8'h78); applyStimulus(8'h56);
    checkOutput("midrst_wr_en", 32'(fifo_wr_en), 32'd1);
    checkOutput("midrst_frame", fifo_wr_data, 32'h1234_5678);

    // Full FIFO drops the frame.
    fifo_full = 1'b1;
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
    checkOutput("ovf_no_wr", 32'(fifo_wr_en), 32'd0);
    checkOutput("ovf_count", 32'(overflow_count), 32'(STATS));
    fifo_full = 1'b0;

    // Prebuffer then play.
    enable = 1'b1; fifo_fill = 12'd0;
    stepCycle();
    checkOutput("prebuf_state", 32'(state), 32'd1);
    checkOutput("prebuf_mute", 32'(dac_mute), 32'd1);
    rdSeen = 0;
    for (int i = 0; i < 50; i++) begin
      stepCycle();
      if (fifo_rd_en) rdSeen++;
    end
    checkOutput("prebuf_no_reads", 32'(rdSeen), 32'd0);
    fifo_fill = 12'd2047;
    stepCycle();
    checkOutput("prebuf_2047_state", 32'(state), 32'd1);
    fifo_fill = 12'd2048;
    stepCycle();
    checkOutput("play_state", 32'(state), 32'd2);
    checkOutput("play_mute", 32'(dac_mute), 32'd0);

    rdSeen = 0;
    for (int i = 0; i < CLK_FREQ; i++) begin
      stepCycle();
      if (fifo_rd_en) rdSeen++;
    end
    checkOutput("tick_count", 32'(rdSeen), 32'(SAMPLE_FREQ));

    // Underrun on the next tick with an empty FIFO.
    fifo_fill = 12'd100;
    stepCycle();
    fifo_empty = 1'b1;
    rdSeen = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (fifo_rd_en) rdSeen++;
      if (state != 2'd2) break;
    end
    checkOutput("underrun_no_read", 32'(rdSeen), 32'd0);
    checkOutput("underrun_state", 32'(state), 32'd1);
    checkOutput("underrun_mute", 32'(dac_mute), 32'd1);
    checkOutput("underrun_count", 32'(underrun_count), 32'(STATS));
    fifo_empty = 1'b0;

    enable = 1'b0;
    stepCycle();
    checkOutput("disable_state", 32'(state), 32'd0);
    checkOutput("disable_mute", 32'(dac_mute), 32'd1);

    // Flow-control hysteresis across the two thresholds.
    for (int i = 0; i < 7; i++) begin
      fifo_fill = 12'(fillTab[i]);
      stepCycle();
      checkOutput($sformatf("host_go_fill_%0d", fillTab[i]), 32'(host_go), 32'(goTab[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
